// File: rtl/stepper_axis_driver.sv
// Single-axis 4-phase full-step stepper driver with direction-reversal dwell and angle tracking.
// Steps every CLK_DIV cycles while the command holds; reversals pause DWELL_STEPS step periods.
module stepper_axis_driver #(
    parameter int CLK_DIV     = 50000,
    parameter int POS_MAX     = 360,
    parameter int DWELL_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  cmd,
    input  logic        pos_load,
    input  logic [15:0] pos_init,
    output logic [3:0]  phase,
    output logic [15:0] pos_actual,
    output logic        step_pulse,
    output logic        moving,
    output logic        load_err
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DWELL_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DWELL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    dir_q, dir_d;
    logic [15:0]   pos_q, pos_d;
    logic [3:0]    phase_q, phase_d;
    logic          step_q, step_d;
    logic          lerr_q, lerr_d;
    logic          tick;
    logic          cmd_go;

    function automatic logic [3:0] phase_pat(input logic [1:0] i);
        case (i)
            2'd0:    return 4'b0011;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b1100;
            default: return 4'b1001;
        endcase
    endfunction

    assign tick   = (presc_q == PW'(CLK_DIV - 1));
    assign cmd_go = (cmd == 2'b01) || (cmd == 2'b10);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        dwell_d = dwell_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        lerr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (pos_load) begin
                    if (pos_init < 16'(POS_MAX)) pos_d = pos_init;
                    else                         lerr_d = 1'b1;
                end
                if (enable && cmd_go) begin
                    state_d = S_RUN;
                    dir_d   = cmd;
                end
            end
            S_RUN: begin
                if (!enable || !cmd_go) begin
                    state_d = S_IDLE;
                end else if (cmd != dir_q) begin
                    state_d = S_DWELL;
                    dwell_d = '0;
                end else if (tick) begin
                    step_d = 1'b1;
                    if (dir_q == 2'b10) begin
                        idx_d = idx_q + 2'd1;
                        pos_d = (pos_q == 16'(POS_MAX - 1)) ? 16'd0 : pos_q + 16'd1;
                    end else begin
                        idx_d = idx_q - 2'd1;
                        pos_d = (pos_q == 16'd0) ? 16'(POS_MAX - 1) : pos_q - 16'd1;
                    end
                end
            end
            default: begin
                // Any valid direction at the end of the dwell restarts motion, even the original one.
                if (!enable || !cmd_go) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    dwell_d = dwell_q + 1'b1;
                    if (dwell_q == DW'(DWELL_STEPS - 1)) begin
                        state_d = S_RUN;
                        dir_d   = cmd;
                    end
                end
            end
        endcase
        if (state_d != state_q) presc_d = '0;
        phase_d = enable ? phase_pat(idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            dwell_q <= '0;
            idx_q   <= 2'd0;
            dir_q   <= 2'd0;
            pos_q   <= 16'd0;
            phase_q <= 4'b0000;
            step_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            lerr_q  <= lerr_d;
        end
    end

    assign phase      = phase_q;
    assign pos_actual = pos_q;
    assign step_pulse = step_q;
    assign moving     = (state_q != S_IDLE);
    assign load_err   = lerr_q;

endmodule

// File: doc/stepper_axis_driver.md
Name: stepper_axis_driver

Overview:
- Consumes one axis's 2-bit direction command (S_out_teta or S_out_fi) from the movement controller.
- Drives a 4-phase full-step stepper motor at a fixed step rate.
- Tracks the axis angle in step units and returns it as the controller's teta_actual/fi_actual feedback.
- Instantiated once per axis, vertical (teta) and horizontal (fi).

Parameters:
- CLK_DIV, 50000: clk cycles per step period; must be >= 2.
- POS_MAX, 360: position modulus; pos_actual stays in 0..POS_MAX-1.
- DWELL_STEPS, 4: step periods the coils are held still before a direction reversal.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  axis enable; low de-energises the coils.
- cmd  in  2  01 = decrement (left/down), 10 = increment (right/up), 00 or 11 = stop.
- pos_load  in  1  one-cycle request to load pos_init into pos_actual.
- pos_init  in  16  preset angle.
- phase  out  4  coil drive pattern A,B,C,D.
- pos_actual  out  16  current angle, fed back to the controller.
- step_pulse  out  1  one-cycle strobe per executed step.
- moving  out  1  high when state is not IDLE.
- load_err  out  1  one-cycle strobe when a load is rejected.

Behaviour:
- Reset, asynchronous: state IDLE, phase index 0, phase=0000, pos_actual=0, step_pulse=0, moving=0, load_err=0, prescaler=0, dwell counter=0, latched dir=0.
- Phase table (index -> pattern): 0 -> 0011, 1 -> 0110, 2 -> 1100, 3 -> 1001.
  - phase = table[index] when enable=1; phase = 0000 when enable=0.
  - The index is retained across disable.
- States: IDLE, RUN, DWELL.
- Prescaler counts 0..CLK_DIV-1 in RUN and DWELL only. "tick" = prescaler==CLK_DIV-1. The prescaler wraps to 0 on tick and is cleared on every state change.
- IDLE:
  - If enable and cmd is 01 or 10: latch dir=cmd, go to RUN next edge.
  - Otherwise stay. pos_load is honoured only here.
- RUN:
  - On tick with cmd==dir, at a single edge: index +/-1 mod 4; pos_actual +/-1 with wrap (POS_MAX-1 + 1 -> 0, 0 - 1 -> POS_MAX-1); step_pulse=1 for that one cycle.
  - First step occurs exactly CLK_DIV cycles after entering RUN.
  - cmd stop (00/11) at any cycle: go to IDLE next edge, no further step. A coincident tick does not step.
  - cmd opposite to dir at any cycle: go to DWELL next edge, no step, dwell counter=0.
- DWELL:
  - Coils hold the current pattern.
  - Each tick increments the dwell counter. When it reaches DWELL_STEPS: if cmd is 01/10, latch dir=cmd and enter RUN; otherwise enter IDLE.
  - cmd stop before then: go to IDLE next edge.
  - cmd back to the original direction does not shorten the dwell.
- enable low in any state: go to IDLE next edge and clear the prescaler.
  - pos_actual and index are unchanged.
  - A tick on that same edge does not step.
- pos_load (pulse, IDLE only):
  - If pos_init < POS_MAX: pos_actual=pos_init next edge.
  - Otherwise pos_actual is unchanged and load_err=1 for one cycle.
  - pos_load in RUN/DWELL is ignored silently.
  - pos_load coincident with an IDLE->RUN start: the load wins, and RUN is still entered.
- Arithmetic: pos_actual is unsigned 16-bit; wrap uses compare-and-set, not a modulo operator.
- moving = (state != IDLE), registered with the state.

Test Plan (CLK_DIV=4, POS_MAX=360, DWELL_STEPS=2):
- Reset mid-RUN at pos 10 -> phase=0000, pos_actual=0, moving=0 immediately, without waiting for clk.
- enable=1, cmd=10 held 13 cycles from IDLE -> moving=1 after 1 edge; step_pulse at cycles 5, 9, 13; pos_actual 1, 2, 3; phase 0110, 1100, 1001.
- Load pos_init=359, then cmd=10 for one step -> pos_actual=0. Then cmd=01 through dwell -> pos_actual=359 after dwell plus one step.
- cmd 10 -> 01 while running -> no step_pulse for 8 cycles (2 ticks) of DWELL, then decrements begin 4 cycles after RUN re-entry.
- enable dropped during RUN at pos 7 -> phase=0000, moving=0, pos_actual stays 7. Re-enable -> phase returns to the held pattern.
- pos_init=400 in IDLE -> load_err one cycle, pos_actual unchanged. pos_load during RUN -> ignored, no load_err.
